// File: rtl/bsg_wait_sequencer.sv
// Multi-stage bring-up sequencer: one activate pulse per stage, each gated by the previous stage's wait.
// Optional restart from DONE on start_i is enabled by defining BSG_WAIT_SEQUENCER_RESTART_EN.
module bsg_wait_sequencer #(
    parameter int stages_p = 4,
    parameter int width_p  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [stages_p*width_p-1:0] stage_cycles_i,
    output logic [stages_p-1:0]         activate_o,
    output logic [stages_p-1:0]         ready_o,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int               IDX_W    = (stages_p > 1) ? $clog2(stages_p) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(stages_p - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [IDX_W-1:0]            r_idx;
    logic [IDX_W-1:0]            w_idx_nxt;
    logic [width_p-1:0]          r_cnt;
    logic [width_p-1:0]          w_cnt_nxt;
    logic [stages_p-1:0]         r_ready;
    logic [stages_p-1:0]         w_ready_nxt;
    logic [stages_p*width_p-1:0] r_snap;
    logic                        w_snap_load;
    logic [width_p-1:0]          w_stage_cnt;
    logic [stages_p-1:0]         w_idx_onehot;

    assign w_stage_cnt  = r_snap[r_idx*width_p +: width_p];
    assign w_idx_onehot = stages_p'(1) << r_idx;

    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        w_snap_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_snap_load = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                w_cnt_nxt   = w_stage_cnt;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_ready_nxt = r_ready | w_idx_onehot;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = S_PULSE;
                    end
                end
            end
            S_DONE: begin
`ifdef BSG_WAIT_SEQUENCER_RESTART_EN
                if (start_i) begin
                    w_ready_nxt = '0;
                    w_snap_load = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_PULSE;
                end
`else
                w_state_nxt = S_DONE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_ready <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // NOTE: the count snapshot is data-only storage, always written on start before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_snap_load) begin
            r_snap <= stage_cycles_i;
        end
    end

    assign activate_o = (r_state == S_PULSE) ? w_idx_onehot : '0;
    assign ready_o    = r_ready;
    assign busy_o     = (r_state == S_PULSE) || (r_state == S_WAIT);
    assign done_o     = (r_state == S_DONE);

endmodule

// File: tb/tb_bsg_wait_sequencer.sv
// Self-checking bench for bsg_wait_sequencer: constant timing table, hand sequences, and randomized runs
// against an event-time model (activate/ready cycles computed from the per-stage counts).
`timescale 1ns/1ps
module tb_bsg_wait_sequencer;
    localparam int S = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic [S*W-1:0]   stage_cycles_i;
    logic [S-1:0]     activate_o;
    logic [S-1:0]     ready_o;
    logic             busy_o;
    logic             done_o;

    logic             start2;
    logic [3:0]       cycles2;
    logic [0:0]       act2;
    logic [0:0]       rdy2;
    logic             busy2;
    logic             done2;

    bsg_wait_sequencer #(.stages_p(S), .width_p(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .stage_cycles_i (stage_cycles_i),
        .activate_o     (activate_o),
        .ready_o        (ready_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    bsg_wait_sequencer #(.stages_p(1), .width_p(4)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start2),
        .stage_cycles_i (cycles2),
        .activate_o     (act2),
        .ready_o        (rdy2),
        .busy_o         (busy2),
        .done_o         (done2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Expected {activate, ready, busy, done} at cycle cyc after the start edge (cycle 1 = first activate).
    function automatic logic [9:0] model(input logic [S-1:0][W-1:0] c, input int cyc);
        logic [S-1:0] act;
        logic [S-1:0] rdy;
        int           a;
        act = '0;
        rdy = '0;
        a   = 1;
        for (int k = 0; k < S; k++) begin
            if (cyc == a) act[k] = 1'b1;
            a = a + int'(c[k]) + 2;
            if (cyc >= a) rdy[k] = 1'b1;
        end
        return {act, rdy, (cyc >= 1 && cyc < a), (cyc >= a)};
    endfunction

    function automatic int seq_len(input logic [S-1:0][W-1:0] c);
        int a;
        a = 1;
        for (int k = 0; k < S; k++) a = a + int'(c[k]) + 2;
        return a;
    endfunction

    typedef struct packed {
        logic [S-1:0][W-1:0]  c;
        logic                 hold;
        logic                 mutate;
        logic [S-1:0][15:0]   exp_act;
        logic [15:0]          exp_fin;
    } vec_t;

    function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                                input bit h, input bit m,
                                input int a0, input int a1, input int a2, input int a3, input int f);
        vec_t v;
        v.c          = {W'(c3), W'(c2), W'(c1), W'(c0)};
        v.hold       = h;
        v.mutate     = m;
        v.exp_act    = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        v.exp_fin    = 16'(f);
        return v;
    endfunction

    int rec_act[S];
    int rec_fin;

    task automatic run_seq(input logic [S-1:0][W-1:0] c, input bit hold, input bit mutate,
                           input bit rnd, input bit do_reset, input string tag);
        int          fin;
        logic [9:0]  got;
        fin = seq_len(c);
        if (do_reset) begin
            reset   = 1'b1;
            start_i = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
        end
        for (int k = 0; k < S; k++) rec_act[k] = -1;
        rec_fin        = -1;
        stage_cycles_i = c;
        start_i        = 1'b1;
        for (int cyc = 1; cyc <= fin + 4; cyc++) begin
            @(posedge clk);
            #1;
            got = {activate_o, ready_o, busy_o, done_o};
            check($sformatf("%s cyc%0d", tag, cyc), 32'(got), 32'(model(c, cyc)));
            for (int k = 0; k < S; k++) if (activate_o[k] && rec_act[k] < 0) rec_act[k] = cyc;
            if (done_o && rec_fin < 0) rec_fin = cyc;
            if (hold) start_i = (cyc < 20);
            else if (rnd) start_i = 1'($urandom);
            else start_i = 1'b0;
`ifdef BSG_WAIT_SEQUENCER_RESTART_EN
            if (cyc >= fin) start_i = 1'b0;
`endif
            if (mutate && cyc == 1) stage_cycles_i = '1;
            if (rnd) stage_cycles_i = $urandom;
        end
        start_i = 1'b0;
    endtask

    task automatic check_times(input vec_t v, input string tag);
        for (int k = 0; k < S; k++)
            check($sformatf("%s act%0d_cycle", tag, k), 32'(rec_act[k]), 32'(v.exp_act[k]));
        check($sformatf("%s done_cycle", tag), 32'(rec_fin), 32'(v.exp_fin));
    endtask

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [S-1:0][W-1:0] c;
        logic [S-1:0][W-1:0] base;

        reset          = 1'b1;
        start_i        = 1'b0;
        stage_cycles_i = '0;
        start2         = 1'b0;
        cycles2        = '0;

        vecs[0] = mk(3, 0, 1, 5,   0, 0, 1, 6,   8,   11,  18);
        vecs[1] = mk(3, 0, 1, 5,   1, 0, 1, 6,   8,   11,  18);
        vecs[2] = mk(3, 0, 1, 5,   0, 1, 1, 6,   8,   11,  18);
        vecs[3] = mk(0, 0, 0, 0,   0, 0, 1, 3,   5,   7,   9);
        vecs[4] = mk(2, 4, 0, 1,   0, 0, 1, 5,   11,  13,  16);
        vecs[5] = mk(255, 0, 0, 1, 0, 0, 1, 258, 260, 262, 265);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({activate_o, ready_o, busy_o, done_o}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].c, vecs[i].hold, vecs[i].mutate, 1'b0, 1'b1, $sformatf("vec%0d", i));
            check_times(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during stage 2's WAIT, then a fresh start must reproduce the base timing.
        base    = vecs[0].c;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset          = 1'b0;
        stage_cycles_i = base;
        start_i        = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            check($sformatf("prerst cyc%0d", cyc), 32'({activate_o, ready_o, busy_o, done_o}),
                  32'(model(base, cyc)));
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_outputs", 32'({activate_o, ready_o, busy_o, done_o}), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle", 32'({activate_o, ready_o, busy_o, done_o}), 32'd0);
        run_seq(base, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");
        check_times(vecs[0], "after_rst");

        // Reset and start together: reset wins, and no sequence follows.
        reset   = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        check("rst_and_start", 32'({activate_o, ready_o, busy_o, done_o}), 32'd0);
        reset   = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_and_start_idle", 32'({activate_o, ready_o, busy_o, done_o}), 32'd0);

        // Single stage, 4-bit count at its maximum: done 17 cycles after the activate cycle.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        cycles2 = 4'hF;
        start2  = 1'b1;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(posedge clk);
            #1;
            start2 = 1'b0;
            check($sformatf("w4 cyc%0d", cyc), 32'({act2, rdy2, busy2, done2}),
                  32'({(cyc == 1), (cyc >= 18), (cyc < 18), (cyc >= 18)}));
        end

`ifdef BSG_WAIT_SEQUENCER_RESTART_EN
        run_seq(base, 1'b0, 1'b0, 1'b0, 1'b1, "pre_restart");
        c = {W'(0), W'(0), W'(2), W'(1)};
        run_seq(c, 1'b0, 1'b0, 1'b0, 1'b0, "restart");
        check("restart done_cycle", 32'(rec_fin), 32'd12);
        check("restart act0_cycle", 32'(rec_act[0]), 32'd1);
`endif

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < S; k++) c[k] = W'($urandom_range(0, 15));
            run_seq(c, 1'b0, 1'b0, 1'b1, 1'b1, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
